if_fetch: RTL and testbench
===========================

# if_fetch

Instruction-fetch stage of the SWIS-V pipeline. It owns the architectural PC and issues word fetches to instruction memory over a request/grant/response handshake. It passes fetched instructions to ID over a valid/ready handshake. It consumes the redirect signals produced by EX (branch-or-JAL, JALR, ALU result, immediate, EX PC) and kills fetches in flight when a redirect occurs.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk` in 1: the single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `i_boj` in 1: taken branch or JAL from EX.
- `i_jalr` in 1: JALR from EX.
- `i_ex_pc` in 32: PC of the EX instruction.
- `i_imm_data` in 32: immediate of the EX instruction.
- `i_result` in 32: EX ALU result, which is the JALR target before masking.
- `o_imem_req` out 1: fetch request.
- `o_imem_addr` out 32: fetch address.
- `i_imem_gnt` in 1: request accepted this cycle.
- `i_imem_rvalid` in 1: response valid.
- `i_imem_rdata` in 32: response instruction.
- `o_valid` out 1: instruction valid toward ID.
- `o_instr` out 32: instruction toward ID.
- `o_pc` out 32: PC of `o_instr`.
- `i_id_ready` in 1: ID accepts this cycle.
- `o_misalign` out 1: misaligned redirect trap. Exists only with the macro.
- `o_misalign_addr` out 32: offending target. Exists only with the macro.

## Operation
- Redirect: `redir = i_boj | i_jalr`.
  - Target when `i_jalr` is set: `{i_result[31:1],1'b0}`.
  - Otherwise: `i_ex_pc + i_imm_data`, mod 2^32, wrap-around ignored.
  - `i_jalr` has priority if both are set.
- State machine states: IDLE, REQ, WAIT, FULL, plus TRAP under the macro.
  - IDLE goes to REQ unconditionally.
  - In REQ, `o_imem_req=1` and `o_imem_addr=pc`. On `gnt`: `pc_out<=pc`, `pc<=pc+4`, go to WAIT.
  - In WAIT, on `rvalid`, one of three things happens:
    - `drop` is set: discard the response, clear `drop`, go to REQ.
    - The output slot is free (`!o_valid | i_id_ready`): load `o_instr`/`o_pc`, set `o_valid=1`, go to REQ.
    - Otherwise: latch into a one-entry skid buffer, go to FULL.
  - In FULL, on `i_id_ready`: move skid to output, go to REQ.
- ID handshake:
  - `o_valid` drops after a transfer unless a new instruction loads in the same cycle.
  - `o_instr` and `o_pc` stay stable while `o_valid & !i_id_ready`.
- At most one imem request is outstanding. `o_imem_addr` stays stable from the first `req` cycle until `gnt`, unless a redirect occurs.
- A redirect overrides everything in the same cycle. It always sets `pc<=target`, `o_valid<=0`, and clears the skid. Next state depends on the current state:
  - REQ without `gnt`: stay in REQ.
  - REQ with `gnt`: go to WAIT with `drop=1`.
  - WAIT without `rvalid`: stay in WAIT with `drop=1`.
  - WAIT with `rvalid`: discard the response, go to REQ.
  - FULL: go to REQ.
  - IDLE: stay in IDLE (IDLE goes to REQ next cycle regardless).
- Reset, including assertion mid-transaction:
  - State IDLE, `pc=RESET_PC`, `drop=0`.
  - `o_valid=0`, `o_instr=0`, `o_pc=0`, `o_imem_req=0`, `o_imem_addr=RESET_PC`.
  - `o_misalign=0`, `o_misalign_addr=0`.
  - The imem side must tolerate abandoned requests.

## Timing
- `o_imem_req` is combinational from state: `o_imem_req = (state==REQ)`.
- All other outputs are registered.
- First request is in the first cycle after `rst_n` rises.
- `gnt` may coincide with `req`. `rvalid` comes no earlier than the cycle after `gnt`.
- Zero-wait memory gives one instruction per 2 cycles.
- Redirect penalty: the target appears on `o_imem_addr` in the cycle after `redir`.
- Instruction latency: `o_valid` rises in the cycle after `rvalid`.

## Configuration
- `IF_MISALIGN_TRAP_EN` defined:
  - A redirect target with bits [1:0] != 0 enters TRAP.
  - In TRAP: no requests, `o_misalign=1`, `o_misalign_addr=target`. Both are held.
  - A subsequent aligned redirect clears the trap and fetches the new target.
  - A pending in-flight response is still dropped.
- Macro undefined:
  - Target bits [1:0] are forced to 0.
  - `o_misalign` and `o_misalign_addr` ports and TRAP are absent.

## Test plan
- Reset release, `RESET_PC=0x100`, `gnt`/`rvalid` zero-wait, ID always ready -> addresses 0x100, 0x104, 0x108. `o_valid` pulses every 2 cycles with matching `o_pc`.
- `gnt` delayed 3 cycles -> `o_imem_addr` holds 0x100 with `req=1` throughout; single fetch.
- `i_id_ready=0` for 5 cycles after first instruction -> second response goes to FULL, no third request, and both instructions are delivered in order once ready.
- `i_boj=1`, `i_ex_pc=0x200`, `i_imm_data=0xFFFFFFF8` while in WAIT -> late response discarded, next address 0x1F8, `o_valid` is 0 until the 0x1F8 instruction arrives.
- `i_jalr=1`, `i_result=0x0000_0305` in the same cycle as `rvalid` -> response dropped, next address 0x304, no stale `o_valid`.
- With `IF_MISALIGN_TRAP_EN`, `i_boj`, `i_ex_pc=0x400`, `i_imm_data=0x6` -> `o_misalign=1`, `o_misalign_addr=0x406`, `req` stays 0. Then `i_jalr` with `i_result=0x500` -> trap clears and fetch resumes at 0x500.

Source files
------------

// File: rtl/if_fetch.sv
// SWIS-V instruction fetch stage: owns the PC, fetches over imem, feeds ID.
// Optional misaligned-redirect trap: define IF_MISALIGN_TRAP_EN.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_boj,
  input  logic        i_jalr,
  input  logic [31:0] i_ex_pc,
  input  logic [31:0] i_imm_data,
  input  logic [31:0] i_result,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  input  logic        i_id_ready
`ifdef IF_MISALIGN_TRAP_EN
  ,
  output logic        o_misalign,
  output logic [31:0] o_misalign_addr
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_FULL = 3'd3,
    S_TRAP = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fpc_q, fpc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] opc_q, opc_d;
  logic        valid_q, valid_d;
  logic        drop_q, drop_d;

  logic        redir;
  logic        slot_free;
  logic [31:0] tgt_raw;
  logic [31:0] tgt;

  assign redir     = i_boj | i_jalr;
  assign slot_free = !valid_q | i_id_ready;
  assign tgt_raw   = i_jalr ? {i_result[31:1], 1'b0}
                            : i_ex_pc + i_imm_data;

`ifdef IF_MISALIGN_TRAP_EN
  logic        mis;
  logic        mis_q, mis_d;
  logic [31:0] maddr_q, maddr_d;
  logic        unused_res;

  assign tgt        = tgt_raw;
  assign mis        = redir & (tgt_raw[1:0] != 2'b00);
  assign unused_res = i_result[0];
`else
  logic        unused_bits;

  assign tgt         = {tgt_raw[31:2], 2'b00};
  assign unused_bits = i_result[0] ^ (^tgt_raw[1:0]);
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a redirect overrides the normal flow
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ:  if (i_imem_gnt) state_d = S_WAIT;
      S_WAIT: if (i_imem_rvalid)
                state_d = (drop_q || slot_free) ? S_REQ : S_FULL;
      S_FULL: if (i_id_ready) state_d = S_REQ;
`ifdef IF_MISALIGN_TRAP_EN
      S_TRAP: state_d = S_TRAP;
`endif
      default: state_d = S_IDLE;
    endcase
    if (redir) begin
      unique case (state_q)
        S_IDLE:  state_d = S_IDLE;
        S_REQ:   state_d = i_imem_gnt ? S_WAIT : S_REQ;
        S_WAIT:  state_d = i_imem_rvalid ? S_REQ : S_WAIT;
        S_FULL:  state_d = S_REQ;
        default: state_d = (drop_q && !i_imem_rvalid) ? S_WAIT : S_REQ;
      endcase
`ifdef IF_MISALIGN_TRAP_EN
      if (mis) state_d = S_TRAP;
`endif
    end
  end

  // Datapath next-state: PC, drop flag, output slot and skid entry
  always_comb begin
    pc_d         = pc_q;
    fpc_d        = fpc_q;
    drop_d       = drop_q;
    valid_d      = valid_q & !i_id_ready;
    instr_d      = instr_q;
    opc_d        = opc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    unique case (state_q)
      S_REQ: begin
        if (i_imem_gnt) begin
          fpc_d = pc_q;
          pc_d  = pc_q + 32'd4;
        end
      end
      S_WAIT: begin
        if (i_imem_rvalid) begin
          if (drop_q) begin
            drop_d = 1'b0;
          end else if (slot_free) begin
            valid_d = 1'b1;
            instr_d = i_imem_rdata;
            opc_d   = fpc_q;
          end else begin
            skid_instr_d = i_imem_rdata;
            skid_pc_d    = fpc_q;
          end
        end
      end
      S_FULL: begin
        if (i_id_ready) begin
          valid_d = 1'b1;
          instr_d = skid_instr_q;
          opc_d   = skid_pc_q;
        end
      end
      S_TRAP: begin
        if (i_imem_rvalid) drop_d = 1'b0;
      end
      default: ;
    endcase
    if (redir) begin
      pc_d         = tgt;
      valid_d      = 1'b0;
      skid_instr_d = '0;
      skid_pc_d    = '0;
      unique case (state_q)
        S_REQ:   drop_d = i_imem_gnt;
        S_WAIT:  drop_d = !i_imem_rvalid;
        default: ;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      fpc_q        <= '0;
      drop_q       <= 1'b0;
      valid_q      <= 1'b0;
      instr_q      <= '0;
      opc_q        <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else begin
      pc_q         <= pc_d;
      fpc_q        <= fpc_d;
      drop_q       <= drop_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      opc_q        <= opc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

`ifdef IF_MISALIGN_TRAP_EN
  // Trap status: set by a misaligned redirect, cleared by an aligned one
  always_comb begin
    mis_d   = mis_q;
    maddr_d = maddr_q;
    if (redir) begin
      mis_d   = mis;
      maddr_d = mis ? tgt : 32'h0;
    end
  end

  // Trap status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_q   <= 1'b0;
      maddr_q <= '0;
    end else begin
      mis_q   <= mis_d;
      maddr_q <= maddr_d;
    end
  end

  assign o_misalign      = mis_q;
  assign o_misalign_addr = maddr_q;
`endif

  // Outputs: request decoded from state, the rest straight from registers
  assign o_imem_req  = (state_q == S_REQ);
  assign o_imem_addr = pc_q;
  assign o_valid     = valid_q;
  assign o_instr     = instr_q;
  assign o_pc        = opc_q;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: imem responder, ID scoreboard,
// redirect vector table and hand-written stall/redirect sequences.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_boj = 1'b0;
  logic        i_jalr = 1'b0;
  logic [31:0] i_ex_pc = '0;
  logic [31:0] i_imm_data = '0;
  logic [31:0] i_result = '0;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt = 1'b0;
  logic        i_imem_rvalid = 1'b0;
  logic [31:0] i_imem_rdata = '0;
  logic        o_valid;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic        i_id_ready = 1'b1;
`ifdef IF_MISALIGN_TRAP_EN
  logic        o_misalign;
  logic [31:0] o_misalign_addr;
`endif

  always #5 clk = ~clk;

  if_fetch #(.RESET_PC(32'h0000_0100)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_boj        (i_boj),
    .i_jalr       (i_jalr),
    .i_ex_pc      (i_ex_pc),
    .i_imm_data   (i_imm_data),
    .i_result     (i_result),
    .o_imem_req   (o_imem_req),
    .o_imem_addr  (o_imem_addr),
    .i_imem_gnt   (i_imem_gnt),
    .i_imem_rvalid(i_imem_rvalid),
    .i_imem_rdata (i_imem_rdata),
    .o_valid      (o_valid),
    .o_instr      (o_instr),
    .o_pc         (o_pc),
    .i_id_ready   (i_id_ready)
`ifdef IF_MISALIGN_TRAP_EN
    ,
    .o_misalign     (o_misalign),
    .o_misalign_addr(o_misalign_addr)
`endif
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } item_t;

  typedef struct {
    logic        boj;
    logic        jalr;
    logic [31:0] ex_pc;
    logic [31:0] imm;
    logic [31:0] res;
    logic [31:0] exp;
  } vec_t;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  item_t       sb[$];
  logic [31:0] gq[$];
  int          dcyc[$];

  always @(posedge clk) cyc++;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a);
    item_t e;
    e.pc    = a;
    e.instr = mem(a);
    sb.push_back(e);
  endtask

  // imem responder: grant after gdelay waiting cycles, respond rdelay
  // cycles after the cycle following the grant, at most budget grants
  bit          mem_en = 1'b0;
  int          gdelay = 0;
  int          rdelay = 0;
  int          budget = 0;
  bit          gnt_now = 1'b0;
  bit          pend = 1'b0;
  int          wcnt = 0;
  int          rcnt = 0;
  logic [31:0] gaddr = '0;
  logic [31:0] paddr = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      gnt_now       = 1'b0;
      pend          = 1'b0;
      wcnt          = 0;
      i_imem_gnt    = 1'b0;
      i_imem_rvalid = 1'b0;
    end else begin
      if (gnt_now) begin
        pend  = 1'b1;
        paddr = gaddr;
        rcnt  = 0;
      end
      i_imem_rvalid = 1'b0;
      if (pend) begin
        if (rcnt == rdelay) begin
          i_imem_rvalid = 1'b1;
          i_imem_rdata  = mem(paddr);
          pend          = 1'b0;
        end else begin
          rcnt++;
        end
      end
      gnt_now    = 1'b0;
      i_imem_gnt = 1'b0;
      if (mem_en && o_imem_req && budget > 0) begin
        if (wcnt >= gdelay) begin
          i_imem_gnt = 1'b1;
          gnt_now    = 1'b1;
          gaddr      = o_imem_addr;
          gq.push_back(o_imem_addr);
          wcnt = 0;
          budget--;
        end else begin
          wcnt++;
        end
      end
    end
  end

  // ID side monitor: scoreboard pop on transfer, stability while stalled
  bit          hold = 1'b0;
  bit          predir = 1'b0;
  logic [31:0] hinstr = '0;
  logic [31:0] hpc = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (hold && !predir) begin
        checks++;
        if (!(o_valid && o_instr == hinstr && o_pc == hpc)) begin
          fails++;
          $display("FAIL hold_stable: got v=%b i=%h pc=%h expected v=1 i=%h pc=%h",
                   o_valid, o_instr, o_pc, hinstr, hpc);
        end
      end
      if (o_valid && i_id_ready) begin
        dcyc.push_back(cyc);
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_delivery: got pc=%h instr=%h expected none",
                   o_pc, o_instr);
        end else begin
          item_t e;
          e = sb.pop_front();
          chk("deliver_pc", o_pc, e.pc);
          chk("deliver_instr", o_instr, e.instr);
        end
      end
      hold   = o_valid && !i_id_ready;
      hinstr = o_instr;
      hpc    = o_pc;
      predir = i_boj | i_jalr;
    end else begin
      hold   = 1'b0;
      predir = 1'b0;
    end
  end

  task automatic do_reset();
    rst_n      = 1'b0;
    mem_en     = 1'b0;
    budget     = 0;
    gdelay     = 0;
    rdelay     = 0;
    i_boj      = 1'b0;
    i_jalr     = 1'b0;
    i_id_ready = 1'b1;
    #1;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_instr", o_instr, 32'd0);
    chk("rst_pc", o_pc, 32'd0);
    chk("rst_req", 32'(o_imem_req), 32'd0);
    chk("rst_addr", o_imem_addr, 32'h100);
`ifdef IF_MISALIGN_TRAP_EN
    chk("rst_mis", 32'(o_misalign), 32'd0);
    chk("rst_mis_addr", o_misalign_addr, 32'd0);
`endif
    tick();
    tick();
    sb.delete();
    gq.delete();
    dcyc.delete();
    rst_n = 1'b1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n && sb.size() != 0; i++) tick();
    chk("drain_left", 32'(sb.size()), 32'd0);
  endtask

  vec_t tbl[$];
  int   t0;

  initial begin
    #2;
    do_reset();

    // Zero-wait streaming
    budget = 3;
    mem_en = 1'b1;
    push(32'h100);
    push(32'h104);
    push(32'h108);
    tick();
    t0 = cyc;
    chk("first_req", 32'(o_imem_req), 32'd1);
    chk("first_addr", o_imem_addr, 32'h100);
    drain(40);
    chk("zw_gnt_cnt", 32'(gq.size()), 32'd3);
    if (gq.size() >= 3) begin
      chk("zw_a0", gq[0], 32'h100);
      chk("zw_a1", gq[1], 32'h104);
      chk("zw_a2", gq[2], 32'h108);
    end
    if (dcyc.size() >= 3) begin
      chk("zw_latency", 32'(dcyc[0] - t0), 32'd2);
      chk("zw_rate1", 32'(dcyc[1] - dcyc[0]), 32'd2);
      chk("zw_rate2", 32'(dcyc[2] - dcyc[1]), 32'd2);
    end

    // Grant delayed three cycles
    do_reset();
    gdelay = 3;
    budget = 1;
    mem_en = 1'b1;
    push(32'h100);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("gd_req%0d", i), 32'(o_imem_req), 32'd1);
      chk($sformatf("gd_addr%0d", i), o_imem_addr, 32'h100);
      tick();
    end
    drain(40);
    chk("gd_gnt_cnt", 32'(gq.size()), 32'd1);

    // ID stalled: second response parks in the skid entry
    do_reset();
    i_id_ready = 1'b0;
    budget     = 3;
    mem_en     = 1'b1;
    push(32'h100);
    push(32'h104);
    tick();
    for (int i = 0; i < 20 && !o_valid; i++) tick();
    chk("st_valid", 32'(o_valid), 32'd1);
    repeat (5) tick();
    chk("st_gnt_cnt", 32'(gq.size()), 32'd2);
    chk("st_req", 32'(o_imem_req), 32'd0);
    chk("st_pc", o_pc, 32'h100);
    push(32'h108);
    i_id_ready = 1'b1;
    drain(40);

    // Branch redirect while waiting on a late response
    do_reset();
    rdelay = 2;
    budget = 2;
    mem_en = 1'b1;
    push(32'h1F8);
    tick();
    tick();
    chk("br_in_wait", 32'(o_imem_req), 32'd0);
    i_boj      = 1'b1;
    i_ex_pc    = 32'h200;
    i_imm_data = 32'hFFFF_FFF8;
    tick();
    i_boj = 1'b0;
    chk("br_addr", o_imem_addr, 32'h1F8);
    chk("br_valid", 32'(o_valid), 32'd0);
    drain(40);
    if (gq.size() >= 2) chk("br_gnt1", gq[1], 32'h1F8);

    // JALR coincident with the response
    do_reset();
    budget = 2;
    mem_en = 1'b1;
    push(32'h304);
    tick();
    tick();
    i_jalr   = 1'b1;
    i_result = 32'h0000_0305;
    tick();
    i_jalr = 1'b0;
    chk("jr_addr", o_imem_addr, 32'h304);
    chk("jr_valid", 32'(o_valid), 32'd0);
    chk("jr_req", 32'(o_imem_req), 32'd1);
    drain(40);
    if (gq.size() >= 2) chk("jr_gnt1", gq[1], 32'h304);

    // Redirect target table, applied while stuck in REQ
    tbl.push_back('{1'b1, 1'b0, 32'h1000, 32'h20, 32'h0, 32'h1020});
    tbl.push_back('{1'b1, 1'b0, 32'hFFFF_FFF0, 32'h20, 32'h0, 32'h10});
    tbl.push_back('{1'b1, 1'b1, 32'h300, 32'h10, 32'h801, 32'h800});
    tbl.push_back('{1'b0, 1'b1, 32'h0, 32'h0, 32'h0000_4444, 32'h4444});
    tbl.push_back('{1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0});
`ifndef IF_MISALIGN_TRAP_EN
    tbl.push_back('{1'b0, 1'b1, 32'h0, 32'h0, 32'h0000_2003, 32'h2000});
    tbl.push_back('{1'b1, 1'b0, 32'h100, 32'h6, 32'h0, 32'h104});
    tbl.push_back('{1'b0, 1'b1, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFC});
`endif
    do_reset();
    tick();
    foreach (tbl[i]) begin
      i_boj      = tbl[i].boj;
      i_jalr     = tbl[i].jalr;
      i_ex_pc    = tbl[i].ex_pc;
      i_imm_data = tbl[i].imm;
      i_result   = tbl[i].res;
      tick();
      i_boj  = 1'b0;
      i_jalr = 1'b0;
      chk($sformatf("tbl_addr%0d", i), o_imem_addr, tbl[i].exp);
      chk($sformatf("tbl_req%0d", i), 32'(o_imem_req), 32'd1);
    end

`ifdef IF_MISALIGN_TRAP_EN
    // Misaligned branch target traps; aligned JALR releases it
    i_boj      = 1'b1;
    i_ex_pc    = 32'h400;
    i_imm_data = 32'h6;
    tick();
    i_boj = 1'b0;
    chk("tr_mis", 32'(o_misalign), 32'd1);
    chk("tr_mis_addr", o_misalign_addr, 32'h406);
    chk("tr_req", 32'(o_imem_req), 32'd0);
    tick();
    tick();
    chk("tr_mis_hold", 32'(o_misalign), 32'd1);
    chk("tr_req_hold", 32'(o_imem_req), 32'd0);
    i_jalr   = 1'b1;
    i_result = 32'h500;
    tick();
    i_jalr = 1'b0;
    chk("tr_clear", 32'(o_misalign), 32'd0);
    chk("tr_addr", o_imem_addr, 32'h500);
    chk("tr_req_resume", 32'(o_imem_req), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
